// File: rtl/set_assoc_cache_if.sv
// CPU-side and memory-side bus of the set-associative cache.
// slave = cache side, master = requester/memory side (the bench).
interface set_assoc_cache_if;
  logic        req_i;
  logic        write_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        flush_i;
  logic        flush_done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_valid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_i, write_i, be_i, addr_i, data_i, flush_i, mem_valid_i, mem_rdata_i,
    output data_o, valid_o, flush_done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, write_i, be_i, addr_i, data_i, flush_i, mem_valid_i, mem_rdata_i,
    input  data_o, valid_o, flush_done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with round-robin
// replacement, word-serial line refill/writeback and a full flush walk.
module set_assoc_cache #(
  parameter int N_SETS           = 4,
  parameter int N_WAYS           = 2,
  parameter int N_WORDS_PER_LINE = 8
) (
  input logic               clk,
  input logic               rstn_i,
  set_assoc_cache_if.slave  bus
);
  localparam int WB = $clog2(N_WORDS_PER_LINE);
  localparam int IB = $clog2(N_SETS);
  localparam int IW = (IB > 0) ? IB : 1;
  localparam int AW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int TW = 32 - 2 - WB - IB;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FLUSH} state_t;

  // line storage; contents need no reset, only valid/dirty do
  logic [31:0]   r_data [N_SETS][N_WAYS][N_WORDS_PER_LINE];
  logic [TW-1:0] r_tag  [N_SETS][N_WAYS];
  logic [N_SETS-1:0][N_WAYS-1:0] r_valid, r_dirty;
  logic [N_SETS-1:0][AW-1:0]     r_rr;

  state_t        r_state, w_next;
  logic [WB-1:0] r_cnt;     // word within the line being moved
  logic [IW-1:0] r_idx;     // set being refilled / written back / flushed
  logic [AW-1:0] r_vway;    // way being refilled / written back / flushed
  logic [TW-1:0] r_rtag;    // tag of the line being fetched

  logic [WB-1:0] w_word;
  logic [IW-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic [AW-1:0] w_hway, w_vic, w_rr_nxt;
  logic          w_memreq, w_ack, w_last_word, w_last_line, w_fdirty, w_fstep;
  logic [31:0]   w_wb_addr, w_rf_addr;

  // address split; shifts keep this legal when N_SETS == 1
  assign w_word  = WB'(bus.addr_i >> 2);
  assign w_index = IW'((bus.addr_i >> (WB + 2)) & 32'(N_SETS - 1));
  assign w_tag   = TW'(bus.addr_i >> (WB + 2 + IB));
  assign w_vic   = r_rr[w_index];

  // tag compare across the ways of the indexed set
  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    for (int w = 0; w < N_WAYS; w++)
      if (r_valid[w_index][w] && r_tag[w_index][w] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = AW'(w);
      end
  end

  assign w_fdirty    = r_valid[r_idx][r_vway] & r_dirty[r_idx][r_vway];
  assign w_memreq    = (r_state == WRITEBACK) || (r_state == REFILL) ||
                       (r_state == FLUSH && w_fdirty);
  assign w_ack       = bus.mem_valid_i & w_memreq;
  assign w_last_word = (r_cnt == WB'(N_WORDS_PER_LINE - 1));
  assign w_last_line = (r_idx == IW'(N_SETS - 1)) && (r_vway == AW'(N_WAYS - 1));
  // a flush step retires a clean line at once, a dirty one after its last word
  assign w_fstep     = !w_fdirty || (w_ack && w_last_word);
  assign w_rr_nxt    = (r_rr[r_idx] == AW'(N_WAYS - 1)) ? '0 : r_rr[r_idx] + 1'b1;
  assign w_wb_addr   = (32'(r_tag[r_idx][r_vway]) << (WB + 2 + IB)) |
                       (32'(r_idx) << (WB + 2)) | (32'(r_cnt) << 2);
  assign w_rf_addr   = (32'(r_rtag) << (WB + 2 + IB)) |
                       (32'(r_idx) << (WB + 2)) | (32'(r_cnt) << 2);

  // state register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // next-state: a CPU request always wins over a pending flush
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:
        if (bus.req_i && !w_hit)
          w_next = (r_valid[w_index][w_vic] && r_dirty[w_index][w_vic]) ? WRITEBACK : REFILL;
        else if (!bus.req_i && bus.flush_i)
          w_next = FLUSH;
      WRITEBACK: if (w_ack && w_last_word)  w_next = REFILL;
      REFILL:    if (w_ack && w_last_word)  w_next = IDLE;
      FLUSH:     if (w_fstep && w_last_line) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // outputs: memory request fields depend only on registered state,
  // so they hold steady until the word is acknowledged
  always_comb begin
    bus.valid_o      = 1'b0;
    bus.data_o       = r_data[w_index][w_hway][w_word];
    bus.flush_done_o = 1'b0;
    bus.mem_req_o    = w_memreq;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = w_wb_addr;
    bus.mem_wdata_o  = r_data[r_idx][r_vway][r_cnt];
    case (r_state)
      IDLE:      bus.valid_o = bus.req_i & w_hit;
      WRITEBACK: bus.mem_we_o = 1'b1;
      REFILL:    bus.mem_addr_o = w_rf_addr;
      FLUSH: begin
        bus.mem_we_o     = w_fdirty;
        bus.flush_done_o = w_fstep & w_last_line;
      end
      default: ;
    endcase
  end

  // line state, replacement pointers and transfer counters
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_vway  <= '0;
      r_rtag  <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.req_i && w_hit && bus.write_i)
            r_dirty[w_index][w_hway] <= 1'b1;
          else if (bus.req_i && !w_hit) begin
            r_idx  <= w_index;
            r_vway <= w_vic;
            r_rtag <= w_tag;
            r_cnt  <= '0;
          end else if (!bus.req_i && bus.flush_i) begin
            r_idx  <= '0;
            r_vway <= '0;
            r_cnt  <= '0;
          end
        WRITEBACK: if (w_ack) r_cnt <= r_cnt + 1'b1;
        REFILL:
          if (w_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_word) begin
              r_valid[r_idx][r_vway] <= 1'b1;
              r_dirty[r_idx][r_vway] <= 1'b0;
              r_rr[r_idx]            <= w_rr_nxt;
            end
          end
        FLUSH: begin
          if (w_ack) r_cnt <= r_cnt + 1'b1;
          if (w_fstep) begin
            r_valid[r_idx][r_vway] <= 1'b0;
            r_dirty[r_idx][r_vway] <= 1'b0;
            if (r_vway == AW'(N_WAYS - 1)) begin
              r_vway <= '0;
              r_idx  <= w_last_line ? '0 : r_idx + 1'b1;
            end else begin
              r_vway <= r_vway + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // data/tag arrays: byte-masked store hits and word-serial refill
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.req_i && w_hit && bus.write_i)
      for (int b = 0; b < 4; b++)
        if (bus.be_i[b]) r_data[w_index][w_hway][w_word][8*b +: 8] <= bus.data_i[8*b +: 8];
    if (r_state == REFILL && w_ack) begin
      r_data[r_idx][r_vway][r_cnt] <= bus.mem_rdata_i;
      if (w_last_word) r_tag[r_idx][r_vway] <= r_rtag;
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: memory responder records every word transfer,
// test tasks queue the transfers they require and compare them in order.
module tb_set_assoc_cache;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtxn_t;

  logic clk = 1'b0;
  logic rstn;
  set_assoc_cache_if bus ();

  set_assoc_cache #(.N_SETS(4), .N_WAYS(2), .N_WORDS_PER_LINE(8)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rd = 0, n_wr = 0, n_reqcyc = 0, lat = 0;
  int          rd_ptr = 0;
  mtxn_t       obs_mem [$];
  mtxn_t       exp_q   [$];
  logic [31:0] wmem [logic [31:0]];   // memory contents written by the DUT
  logic [31:0] gold [logic [31:0]];   // architectural view after CPU stores
  mtxn_t       e, o;
  int          cyc, k, r;
  logic [31:0] q;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h1122_3344 : (32'hC0DE_0000 | a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  // memory: two cycles per word, records what it served
  always @(negedge clk) begin
    bus.mem_valid_i = 1'b0;
    if (rstn && bus.mem_req_o) n_reqcyc++;
    if (!rstn || !bus.mem_req_o) lat = 0;
    else if (lat == 0) lat = 1;
    else begin
      lat = 0;
      obs_mem.push_back('{we: bus.mem_we_o, addr: bus.mem_addr_o,
                          wdata: bus.mem_we_o ? bus.mem_wdata_o : 32'h0});
      if (bus.mem_we_o) begin
        wmem[bus.mem_addr_o] = bus.mem_wdata_o;
        n_wr++;
      end else begin
        bus.mem_rdata_i = wmem.exists(bus.mem_addr_o) ? wmem[bus.mem_addr_o]
                                                      : init_word(bus.mem_addr_o);
        n_rd++;
      end
      bus.mem_valid_i = 1'b1;
    end
  end

  function automatic void push_line(input logic we, input logic [31:0] base);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{we: we, addr: base + 32'(4 * i),
                        wdata: we ? gold_rd(base + 32'(4 * i)) : 32'h0});
  endfunction

  // one CPU access; returns cycles until valid_o (-1 on timeout) and data_o
  task automatic cpu_access(input logic wr, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] d, output int c, output logic [31:0] dq);
    c = 0;
    bus.req_i = 1'b1; bus.write_i = wr; bus.be_i = be; bus.addr_i = a; bus.data_i = d;
    #1;
    while (!bus.valid_o && c < 300) begin @(negedge clk); c++; end
    dq = bus.data_o;
    if (!bus.valid_o) c = -1;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.write_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.req_i = 0; bus.write_i = 0; bus.be_i = 0; bus.addr_i = 0; bus.data_i = 0; bus.flush_i = 0;
    #1;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", bus.valid_o); end
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b required 0", bus.mem_req_o); end
    n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b required 0", bus.mem_we_o); end
    n_cmp++; if (bus.flush_done_o !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b required 0", bus.flush_done_o); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_load();
    push_line(1'b0, 32'h100);
    cpu_access(1'b0, 4'h0, 32'h100, 32'h0, cyc, q);
    n_cmp++; if (q !== 32'h1122_3344) begin n_err++; $display("FAIL cold_data: got %h required 11223344", q); end
    n_cmp++; if (cyc < 8) begin n_err++; $display("FAIL cold_latency: got %0d cycles required >= 8", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd_ptr >= obs_mem.size()) begin n_err++; $display("FAIL cold_txn: missing, required addr %h", e.addr); end
      else begin o = obs_mem[rd_ptr]; rd_ptr++;
        if (o !== e) begin n_err++; $display("FAIL cold_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    n_cmp++; if (obs_mem.size() != rd_ptr) begin n_err++; $display("FAIL cold_extra: got %0d txns required %0d", obs_mem.size(), rd_ptr); rd_ptr = obs_mem.size(); end
    r = n_reqcyc;
    cpu_access(1'b0, 4'h0, 32'h104, 32'h0, cyc, q);
    n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL hit_latency: got %0d required 0", cyc); end
    n_cmp++; if (q !== 32'hC0DE_0104) begin n_err++; $display("FAIL hit_data: got %h required c0de0104", q); end
    n_cmp++; if (n_reqcyc != r) begin n_err++; $display("FAIL hit_no_mem: got %0d req cycles required 0", n_reqcyc - r); end
  endtask

  task automatic test_store_hit();
    r = n_reqcyc;
    cpu_access(1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD, cyc, q);
    gold[32'h100] = 32'h1122_CCDD;
    n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL store_latency: got %0d required 0", cyc); end
    cpu_access(1'b0, 4'h0, 32'h100, 32'h0, cyc, q);
    n_cmp++; if (q !== 32'h1122_CCDD) begin n_err++; $display("FAIL store_merge: got %h required 1122ccdd", q); end
    n_cmp++; if (n_reqcyc != r) begin n_err++; $display("FAIL store_no_mem: got %0d req cycles required 0", n_reqcyc - r); end
  endtask

  task automatic test_writeback();
    push_line(1'b0, 32'h180);
    cpu_access(1'b0, 4'h0, 32'h184, 32'h0, cyc, q);
    n_cmp++; if (q !== gold_rd(32'h184)) begin n_err++; $display("FAIL wb_fill_data: got %h required %h", q, gold_rd(32'h184)); end
    push_line(1'b1, 32'h100);
    push_line(1'b0, 32'h200);
    cpu_access(1'b0, 4'h0, 32'h21C, 32'h0, cyc, q);
    n_cmp++; if (q !== gold_rd(32'h21C)) begin n_err++; $display("FAIL wb_miss_data: got %h required %h", q, gold_rd(32'h21C)); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd_ptr >= obs_mem.size()) begin n_err++; $display("FAIL wb_txn: missing, required addr %h", e.addr); end
      else begin o = obs_mem[rd_ptr]; rd_ptr++;
        if (o !== e) begin n_err++; $display("FAIL wb_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    n_cmp++; if (obs_mem.size() != rd_ptr) begin n_err++; $display("FAIL wb_extra: got %0d txns required %0d", obs_mem.size(), rd_ptr); rd_ptr = obs_mem.size(); end
    cpu_access(1'b0, 4'h0, 32'h180, 32'h0, cyc, q);
    n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL wb_other_way_hit: got %0d cycles required 0", cyc); end
    n_cmp++; if (q !== gold_rd(32'h180)) begin n_err++; $display("FAIL wb_other_way_data: got %h required %h", q, gold_rd(32'h180)); end
  endtask

  task automatic test_flush();
    push_line(1'b0, 32'h100);
    cpu_access(1'b1, 4'hF, 32'h108, 32'hDEAD_BEEF, cyc, q);
    gold[32'h108] = 32'hDEAD_BEEF;
    n_cmp++; if (cyc <= 0) begin n_err++; $display("FAIL store_miss_latency: got %0d required > 0", cyc); end
    push_line(1'b1, 32'h100);
    bus.flush_i = 1'b1;
    k = 0;
    while (k < 500) begin @(negedge clk); k++; if (bus.flush_done_o) break; end
    n_cmp++; if (bus.flush_done_o !== 1'b1) begin n_err++; $display("FAIL flush_done: got %b required 1", bus.flush_done_o); end
    bus.flush_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.flush_done_o !== 1'b0) begin n_err++; $display("FAIL flush_pulse: got %b required 0", bus.flush_done_o); end
    @(posedge clk); #1;
    push_line(1'b0, 32'h100);
    cpu_access(1'b0, 4'h0, 32'h108, 32'h0, cyc, q);
    n_cmp++; if (cyc <= 0) begin n_err++; $display("FAIL flush_invalidate: got %0d cycles required > 0", cyc); end
    n_cmp++; if (q !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL flush_data: got %h required deadbeef", q); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd_ptr >= obs_mem.size()) begin n_err++; $display("FAIL flush_txn: missing, required addr %h", e.addr); end
      else begin o = obs_mem[rd_ptr]; rd_ptr++;
        if (o !== e) begin n_err++; $display("FAIL flush_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    n_cmp++; if (obs_mem.size() != rd_ptr) begin n_err++; $display("FAIL flush_extra: got %0d txns required %0d", obs_mem.size(), rd_ptr); rd_ptr = obs_mem.size(); end
  endtask

  task automatic test_flush_clean();
    r = n_reqcyc;
    bus.flush_i = 1'b1;
    @(posedge clk);
    k = 0;
    while (k < 100) begin @(negedge clk); k++; if (bus.flush_done_o) break; end
    bus.flush_i = 1'b0;
    n_cmp++; if (k != 8) begin n_err++; $display("FAIL flush_clean_cycles: got %0d required 8", k); end
    n_cmp++; if (n_reqcyc != r) begin n_err++; $display("FAIL flush_clean_no_mem: got %0d req cycles required 0", n_reqcyc - r); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrefill();
    for (int i = 0; i < 3; i++) exp_q.push_back('{we: 1'b0, addr: 32'h300 + 32'(4 * i), wdata: 32'h0});
    push_line(1'b0, 32'h300);
    r = n_rd;
    bus.req_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = 32'h304;
    k = 0;
    while (n_rd - r < 3 && k < 200) begin @(posedge clk); #2; k++; end
    rstn = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_err++; $display("FAIL midreset_mem_req: got %b required 0", bus.mem_req_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b required 0", bus.valid_o); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    k = 0;
    while (!bus.valid_o && k < 300) begin @(negedge clk); k++; end
    q = bus.data_o;
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL midreset_timeout: got valid %b required 1", bus.valid_o); end
    n_cmp++; if (q !== gold_rd(32'h304)) begin n_err++; $display("FAIL midreset_data: got %h required %h", q, gold_rd(32'h304)); end
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rd_ptr >= obs_mem.size()) begin n_err++; $display("FAIL midreset_txn: missing, required addr %h", e.addr); end
      else begin o = obs_mem[rd_ptr]; rd_ptr++;
        if (o !== e) begin n_err++; $display("FAIL midreset_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    n_cmp++; if (obs_mem.size() != rd_ptr) begin n_err++; $display("FAIL midreset_extra: got %0d txns required %0d", obs_mem.size(), rd_ptr); rd_ptr = obs_mem.size(); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_writeback();
    test_flush();
    test_flush_clean();
    test_reset_midrefill();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
